wb_regfile_scoreboard: RTL and testbench
========================================

# wb_regfile_scoreboard

Register file with write-back scoreboard for the pipelined MIPS core: the consumer end of the memory/write-back pipeline register. It selects the write-back result, commits it to a 32 x 32-bit register file, and serves two decode-stage read ports with same-cycle bypass. A per-register pending-write counter tracks results issued by decode but not yet written back, so the hazard logic can stall on true dependencies.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- CNT_W, 2, pending counter width; max in-flight writes per register = 2^CNT_W - 1 (3)

Ports:
- Reset rst, asynchronous, active-low; clock clk.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- issue_valid  in  1  decode issues an instruction that will write issue_reg
- issue_reg  in  ADDR_W  destination register of the issued instruction
- issue_stall  out  1  issue refused: destination counter saturated
- RegWrite_W  in  1  write-back enable
- MemtoReg_W  in  1  1 = write load data, 0 = write ALU result
- WriteReg_W  in  ADDR_W  write-back destination
- ReaData_W  in  DATA_W  load data from write-back stage
- ALUOut_W  in  DATA_W  ALU result from write-back stage
- Result_W  out  DATA_W  selected write-back value (to forwarding muxes)
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data
- busy1, busy2  out  1  read register has an outstanding write
- err_underflow  out  1  sticky: retire seen with zero pending count

## Operation
- Result_W = MemtoReg_W ? ReaData_W : ALUOut_W (combinational).
- Commit: wb_en = RegWrite_W && WriteReg_W != 0; on wb_en, regs[WriteReg_W] <= Result_W at rising clk.
- Register 0: never written, always reads 0, never pending, never busy; issue to reg 0 does not count and never stalls.
- Read ports (combinational): ra == 0 -> 0; else wb_en && WriteReg_W == ra -> Result_W (bypass); else regs[ra].
- Scoreboard: cnt[r] per register.
  - issue_stall = issue_valid && issue_reg != 0 && cnt[issue_reg] == max && !(wb_en && WriteReg_W == issue_reg).
  - inc = issue_valid && issue_reg != 0 && !issue_stall; dec = wb_en.
  - Same register inc and dec in one cycle: count unchanged. Different registers: each updated independently.
  - dec with cnt == 0: count stays 0, err_underflow <= 1 (sticky until reset); data is still committed.
- busy(ra) = ra != 0 && (cnt[ra] - (wb_en && WriteReg_W == ra ? 1 : 0)) != 0. A retiring last write clears busy in the same cycle since the bypass supplies the data. Issue in the same cycle does not affect busy until next cycle.

## Timing
- Reset (async, rst low): all regs = 0, all cnt = 0, err_underflow = 0; thus rd1/rd2 = 0, busy = 0, issue_stall = 0 (with issue_valid = 0).
- Write latency: value visible same cycle via bypass, from regs array from next cycle.
- Counter updates take effect at the rising edge; busy/issue_stall reflect them the following cycle.
- Reset asserted mid-operation discards all pending counts and register contents immediately; no retire after reset release underflows silently (it flags err_underflow).
- No reset-release synchronization inside the block.

## Test plan
- Reset: rst low, then read ra1=5, ra2=31 -> rd1=rd2=0, busy1=busy2=0, err_underflow=0.
- Write/bypass: RegWrite_W=1, WriteReg_W=8, MemtoReg_W=0, ALUOut_W=0xDEADBEEF, ra1=8 -> rd1=0xDEADBEEF same cycle; next cycle with RegWrite_W=0 -> rd1=0xDEADBEEF; MemtoReg_W=1, ReaData_W=0x12345678 to reg 9 -> regs[9]=0x12345678.
- Reg 0: write 0xFFFFFFFF to reg 0 and issue reg 0 -> rd(0)=0, busy=0, err_underflow stays 0.
- Scoreboard: issue reg 3 three cycles -> busy1(ra1=3)=1; fourth issue -> issue_stall=1, count stays 3; same cycle with wb to reg 3 -> no stall, count stays 3; three more retires -> busy1 clears on cycle of last retire.
- Simultaneous: issue reg 4 and retire reg 4 with cnt=1 -> cnt stays 1, busy stays 1.
- Underflow: retire reg 7 with cnt=0 -> data written, err_underflow=1 and held until rst low.

Source files
------------

// File: rtl/wb_regfile_scoreboard.sv
// Write-back register file with per-register pending-write scoreboard and same-cycle read bypass.
// Latency: reads, bypass and busy/stall are combinational; commits and counter updates land at the rising clk edge.
// Backpressure: issue_stall refuses an issue whose destination counter is saturated, unless that register retires this cycle.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   issue_valid/issue_reg    decode issues an instruction writing issue_reg; issue_stall = refused
//   RegWrite_W, MemtoReg_W,  write-back enable, result select, destination,
//   WriteReg_W, ReaData_W,   load data and ALU result from the write-back stage
//   ALUOut_W
//   Result_W                 selected write-back value (to forwarding muxes)
//   ra1/rd1/busy1,           two read ports: address, data (with bypass), outstanding-write flag
//   ra2/rd2/busy2
//   err_underflow            sticky: a retire arrived for a register with zero pending writes
module wb_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              issue_stall,
    input  logic              RegWrite_W,
    input  logic              MemtoReg_W,
    input  logic [ADDR_W-1:0] WriteReg_W,
    input  logic [DATA_W-1:0] ReaData_W,
    input  logic [DATA_W-1:0] ALUOut_W,
    output logic [DATA_W-1:0] Result_W,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    output logic              err_underflow
);

    localparam int               NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];

    logic            wb_en;
    logic            inc;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic            hit1;
    logic            hit2;

    assign Result_W = MemtoReg_W ? ReaData_W : ALUOut_W;

    // Register 0 is hardwired: a write-back to it is neither a commit nor a retire.
    assign wb_en = RegWrite_W && (WriteReg_W != '0);

    // A saturated counter can still accept an issue when the same register
    // retires this cycle, because the net count does not change.
    assign issue_stall = issue_valid && (issue_reg != '0) &&
                         (cnt[issue_reg] == CNT_MAX) &&
                         !(wb_en && (WriteReg_W == issue_reg));

    assign inc = issue_valid && (issue_reg != '0) && !issue_stall;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = inc   && (issue_reg  == ADDR_W'(i));
            dec_vec[i] = wb_en && (WriteReg_W == ADDR_W'(i));
        end
    end

    // Register array commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[WriteReg_W] <= Result_W;
        end
    end

    // Pending-write counters. Issue and retire of the same register cancel;
    // a retire against an empty counter leaves it at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10: cnt[i] <= cnt[i] + CNT_ONE;
                    2'b01: if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_underflow <= 1'b0;
        end else if (wb_en && (cnt[WriteReg_W] == '0)) begin
            err_underflow <= 1'b1;
        end
    end

    // wb_en already excludes register 0, so the hits are never set for ra == 0.
    assign hit1 = wb_en && (WriteReg_W == ra1);
    assign hit2 = wb_en && (WriteReg_W == ra2);

    assign rd1 = (ra1 == '0) ? '0 : (hit1 ? Result_W : regs[ra1]);
    assign rd2 = (ra2 == '0) ? '0 : (hit2 ? Result_W : regs[ra2]);

    // A retiring write is already visible through the bypass, so it no longer
    // counts as outstanding. Compared rather than subtracted so an empty
    // counter with an underflowing retire reads as not busy.
    assign busy1 = (ra1 != '0) && (cnt[ra1] > CNT_W'(hit1));
    assign busy2 = (ra2 != '0) && (cnt[ra2] > CNT_W'(hit2));

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
module tb_wb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        issue_stall;
    logic        RegWrite_W;
    logic        MemtoReg_W;
    logic [4:0]  WriteReg_W;
    logic [31:0] ReaData_W;
    logic [31:0] ALUOut_W;
    logic [31:0] Result_W;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        err_underflow;

    int tests;
    int fails;

    wb_regfile_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_reg     (issue_reg),
        .issue_stall   (issue_stall),
        .RegWrite_W    (RegWrite_W),
        .MemtoReg_W    (MemtoReg_W),
        .WriteReg_W    (WriteReg_W),
        .ReaData_W     (ReaData_W),
        .ALUOut_W      (ALUOut_W),
        .Result_W      (Result_W),
        .ra1           (ra1),
        .ra2           (ra2),
        .rd1           (rd1),
        .rd2           (rd2),
        .busy1         (busy1),
        .busy2         (busy2),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Architectural view: a plain array of values, an integer count of
    // outstanding writes per register, and a sticky error bit.
    logic [31:0] mregs [32];
    int          mcnt  [32];
    bit          merr;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'h0;
            mcnt[i]  = 0;
        end
        merr = 1'b0;
    endtask

    function automatic logic [31:0] m_result();
        return MemtoReg_W ? ReaData_W : ALUOut_W;
    endfunction

    function automatic bit m_wb();
        return RegWrite_W && (WriteReg_W != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (m_wb() && WriteReg_W == a) return m_result();
        return mregs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        int left;
        if (a == 5'd0) return 1'b0;
        left = mcnt[a] - ((m_wb() && WriteReg_W == a) ? 1 : 0);
        return left > 0;
    endfunction

    function automatic bit m_stall();
        return issue_valid && issue_reg != 5'd0 && mcnt[issue_reg] >= 3 &&
               !(m_wb() && WriteReg_W == issue_reg);
    endfunction

    task automatic m_clock();
        bit do_inc;
        bit do_dec;
        do_inc = issue_valid && issue_reg != 5'd0 && !m_stall();
        do_dec = m_wb();
        if (do_dec) begin
            mregs[WriteReg_W] = m_result();
            if (mcnt[WriteReg_W] == 0) merr = 1'b1;
        end
        if (do_inc) mcnt[issue_reg] = mcnt[issue_reg] + 1;
        if (do_dec && mcnt[WriteReg_W] > 0) mcnt[WriteReg_W] = mcnt[WriteReg_W] - 1;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        check({tag, " Result_W"}, Result_W, m_result());
        check({tag, " rd1"}, rd1, m_read(ra1));
        check({tag, " rd2"}, rd2, m_read(ra2));
        check({tag, " busy1"}, 32'(busy1), 32'(m_busy(ra1)));
        check({tag, " busy2"}, 32'(busy2), 32'(m_busy(ra2)));
        check({tag, " issue_stall"}, 32'(issue_stall), 32'(m_stall()));
        check({tag, " err_underflow"}, 32'(err_underflow), 32'(merr));
    endtask

    task automatic set_in(input logic iv, input logic [4:0] ir, input logic rw,
                          input logic m2r, input logic [4:0] wr, input logic [31:0] rdat,
                          input logic [31:0] alu, input logic [4:0] a1, input logic [4:0] a2);
        issue_valid = iv;
        issue_reg   = ir;
        RegWrite_W  = rw;
        MemtoReg_W  = m2r;
        WriteReg_W  = wr;
        ReaData_W   = rdat;
        ALUOut_W    = alu;
        ra1         = a1;
        ra2         = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic        iv;
        logic [4:0]  ir;
        logic        rw;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic iv, input logic [4:0] ir, input logic rw,
                                 input logic m2r, input logic [4:0] wr, input logic [31:0] rdat,
                                 input logic [31:0] alu, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] erd1, input logic [31:0] erd2,
                                 input logic eb1, input logic eb2, input logic es, input logic ee);
        vec_t v;
        v = {iv, ir, rw, m2r, wr, rdat, alu, a1, a2, erd1, erd2, eb1, eb2, es, ee};
        return v;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        m_reset();

        //           iv ir  rw m2r wr  rdat          alu           ra1 ra2  rd1           rd2           b1 b2 st er
        vecs[0]  = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        5,  31, 32'h0,        32'h0,        0, 0, 0, 0);
        vecs[1]  = mkv(1, 8,  0, 0, 0,  32'h0,        32'h0,        8,  0,  32'h0,        32'h0,        0, 0, 0, 0);
        vecs[2]  = mkv(1, 9,  1, 0, 8,  32'h55,       32'hDEADBEEF, 8,  9,  32'hDEADBEEF, 32'h0,        0, 0, 0, 0);
        vecs[3]  = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        8,  9,  32'hDEADBEEF, 32'h0,        0, 1, 0, 0);
        vecs[4]  = mkv(0, 0,  1, 1, 9,  32'h12345678, 32'hAAAA,     9,  8,  32'h12345678, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[5]  = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        9,  0,  32'h12345678, 32'h0,        0, 0, 0, 0);
        vecs[6]  = mkv(1, 0,  1, 0, 0,  32'h0,        32'hFFFFFFFF, 0,  0,  32'h0,        32'h0,        0, 0, 0, 0);
        vecs[7]  = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        0,  9,  32'h0,        32'h12345678, 0, 0, 0, 0);
        vecs[8]  = mkv(1, 3,  0, 0, 0,  32'h0,        32'h0,        3,  0,  32'h0,        32'h0,        0, 0, 0, 0);
        vecs[9]  = mkv(1, 3,  0, 0, 0,  32'h0,        32'h0,        3,  0,  32'h0,        32'h0,        1, 0, 0, 0);
        vecs[10] = mkv(1, 3,  0, 0, 0,  32'h0,        32'h0,        3,  0,  32'h0,        32'h0,        1, 0, 0, 0);
        vecs[11] = mkv(1, 3,  0, 0, 0,  32'h0,        32'h0,        3,  0,  32'h0,        32'h0,        1, 0, 1, 0);
        vecs[12] = mkv(1, 3,  1, 0, 3,  32'h0,        32'h33,       3,  0,  32'h33,       32'h0,        1, 0, 0, 0);
        vecs[13] = mkv(0, 0,  1, 0, 3,  32'h0,        32'h34,       3,  0,  32'h34,       32'h0,        1, 0, 0, 0);
        vecs[14] = mkv(0, 0,  1, 0, 3,  32'h0,        32'h35,       3,  0,  32'h35,       32'h0,        1, 0, 0, 0);
        vecs[15] = mkv(0, 0,  1, 0, 3,  32'h0,        32'h36,       3,  0,  32'h36,       32'h0,        0, 0, 0, 0);
        vecs[16] = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        3,  0,  32'h36,       32'h0,        0, 0, 0, 0);
        vecs[17] = mkv(1, 4,  0, 0, 0,  32'h0,        32'h0,        4,  0,  32'h0,        32'h0,        0, 0, 0, 0);
        vecs[18] = mkv(1, 4,  1, 0, 4,  32'h0,        32'h44,       4,  0,  32'h44,       32'h0,        0, 0, 0, 0);
        vecs[19] = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        4,  0,  32'h44,       32'h0,        1, 0, 0, 0);
        vecs[20] = mkv(0, 0,  1, 0, 4,  32'h0,        32'h45,       4,  0,  32'h45,       32'h0,        0, 0, 0, 0);
        vecs[21] = mkv(0, 0,  1, 0, 7,  32'h0,        32'h77,       7,  4,  32'h77,       32'h45,       0, 0, 0, 0);
        vecs[22] = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        7,  4,  32'h77,       32'h45,       0, 0, 0, 1);
        vecs[23] = mkv(0, 0,  0, 0, 0,  32'h0,        32'h0,        7,  4,  32'h77,       32'h45,       0, 0, 0, 1);

        // ---- reset state, observed while rst is held low ----
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd5, 5'd31);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rd1", rd1, 32'h0);
        check("reset rd2", rd2, 32'h0);
        check("reset busy1", 32'(busy1), 32'h0);
        check("reset busy2", 32'(busy2), 32'h0);
        check("reset issue_stall", 32'(issue_stall), 32'h0);
        check("reset err_underflow", 32'(err_underflow), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed table ----
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].iv, vecs[i].ir, vecs[i].rw, vecs[i].m2r, vecs[i].wr,
                   vecs[i].rdat, vecs[i].alu, vecs[i].ra1, vecs[i].ra2);
            @(negedge clk);
            check($sformatf("vec%0d rd1", i), rd1, vecs[i].e_rd1);
            check($sformatf("vec%0d rd2", i), rd2, vecs[i].e_rd2);
            check($sformatf("vec%0d busy1", i), 32'(busy1), 32'(vecs[i].e_b1));
            check($sformatf("vec%0d busy2", i), 32'(busy2), 32'(vecs[i].e_b2));
            check($sformatf("vec%0d issue_stall", i), 32'(issue_stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d err_underflow", i), 32'(err_underflow), 32'(vecs[i].e_err));
            tick();
        end

        // ---- reset mid-operation: pending counts, data and error all discarded ----
        set_in(1, 10, 0, 0, 0, 32'h0, 32'h0, 5'd10, 5'd0);
        tick();
        tick();
        set_in(0, 0, 1, 0, 10, 32'h0, 32'hA0, 5'd10, 5'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd10, 5'd0);
        @(negedge clk);
        check("pre-reset rd1", rd1, 32'hA0);
        check("pre-reset busy1", 32'(busy1), 32'h1);
        check("pre-reset err_underflow", 32'(err_underflow), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        m_reset();
        check("async reset rd1", rd1, 32'h0);
        check("async reset busy1", 32'(busy1), 32'h0);
        check("async reset err_underflow", 32'(err_underflow), 32'h0);
        #1;
        rst = 1'b1;
        tick();
        set_in(0, 0, 1, 0, 10, 32'h0, 32'hBB, 5'd10, 5'd0);
        @(negedge clk);
        check("post-reset retire rd1", rd1, 32'hBB);
        check("post-reset retire err", 32'(err_underflow), 32'h0);
        tick();
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd10, 5'd0);
        @(negedge clk);
        check("post-reset underflow err", 32'(err_underflow), 32'h1);
        check("post-reset rd1 held", rd1, 32'hBB);
        check("post-reset busy1", 32'(busy1), 32'h0);
        tick();

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 2000; i++) begin
            set_in(($urandom_range(0, 9) < 6),
                   5'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) < 4),
                   1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)),
                   $urandom(),
                   $urandom(),
                   ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
            if (i == 1000) begin
                rst = 1'b0;
                #2;
                m_reset();
                cmp_model("rand-reset");
                #1;
                rst = 1'b1;
            end
            @(negedge clk);
            cmp_model($sformatf("rand%0d", i));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
